hwpe_stream_rr_arbiter: RTL



---
 rtl/hwpe_stream_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hwpe_stream_rr_arbiter.sv
// Round-robin burst arbiter that time-multiplexes NB_IN_STREAMS HWPE streams onto one registered output.
// Optional HWPE_STREAM_ARB_IDLE_RELEASE_EN: drop the grant as soon as the granted producer deasserts valid.
module hwpe_stream_rr_arbiter #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BURST_LEN     = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clear_i,
  input  logic [NB_IN_STREAMS-1:0]                push_valid_i,
  input  logic [NB_IN_STREAMS*DATA_WIDTH-1:0]     push_data_i,
  input  logic [NB_IN_STREAMS*DATA_WIDTH/8-1:0]   push_strb_i,
  output logic [NB_IN_STREAMS-1:0]                push_ready_o,
  output logic                                    pop_valid_o,
  output logic [DATA_WIDTH-1:0]                   pop_data_o,
  output logic [DATA_WIDTH/8-1:0]                 pop_strb_o,
  output logic [((NB_IN_STREAMS > 1) ? $clog2(NB_IN_STREAMS) : 1)-1:0] pop_sel_o,
  input  logic                                    pop_ready_i
);

  localparam int unsigned SEL_W  = (NB_IN_STREAMS > 1) ? $clog2(NB_IN_STREAMS) : 1;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state;
  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W-1:0]    arb_idx;
  logic [SEL_W-1:0]    next_ptr;
  logic [CNT_W-1:0]    beat_cnt;
  logic                any_valid;
  logic                sel_valid;
  logic                out_free;
  logic                accept;
  logic                last_beat;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_W-1:0]   sel_strb;

  // Scan from the highest offset down so the input closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    arb_idx = rr_ptr;
    for (int k = NB_IN_STREAMS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NB_IN_STREAMS)) idx = idx - int'(NB_IN_STREAMS);
      for (int i = 0; i < int'(NB_IN_STREAMS); i++) begin
        if (i == idx && push_valid_i[i]) arb_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    for (int i = 0; i < int'(NB_IN_STREAMS); i++) begin
      if (grant == SEL_W'(i)) begin
        sel_valid = push_valid_i[i];
        sel_data  = push_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = push_strb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  assign any_valid = |push_valid_i;
  assign out_free  = !pop_valid_o || pop_ready_i;
  assign accept    = (state == BUSY) && sel_valid && out_free;
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign next_ptr  = (grant == SEL_W'(NB_IN_STREAMS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    push_ready_o = '0;
    for (int i = 0; i < int'(NB_IN_STREAMS); i++) begin
      if (state == BUSY && grant == SEL_W'(i)) push_ready_o[i] = out_free;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat_cnt    <= '0;
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
      pop_strb_o  <= '0;
      pop_sel_o   <= '0;
    end else if (clear_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      beat_cnt    <= '0;
      pop_valid_o <= 1'b0;
      pop_data_o  <= '0;
      pop_strb_o  <= '0;
      pop_sel_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant    <= arb_idx;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (accept) begin
            if (last_beat) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
`ifdef HWPE_STREAM_ARB_IDLE_RELEASE_EN
          else if (!sel_valid) begin
            state    <= IDLE;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end
`endif
        end
        default: state <= IDLE;
      endcase

      // A new beat and a pop in the same cycle simply replace the register contents.
      if (accept) begin
        pop_valid_o <= 1'b1;
        pop_data_o  <= sel_data;
        pop_strb_o  <= sel_strb;
        pop_sel_o   <= grant;
      end else if (pop_ready_i) begin
        pop_valid_o <= 1'b0;
      end
    end
  end

endmodule
